// File: rtl/scan_line_sequencer_pkg.sv
// Shared types and default sizing for the scan line sequencer.
package scan_seq_pkg;

    localparam int LINE_W_DEF      = 8;
    localparam int LISTEN_W_DEF    = 16;
    localparam int DEAD_W_DEF      = 12;
    localparam int ACK_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FIRE     = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_TX  = 3'd3,
        LISTEN   = 3'd4,
        DEAD     = 3'd5,
        DONE     = 3'd6
    } scan_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/scan_line_sequencer_interval.sv
// Loadable down-counter with zero flag; shared by the ack, listen and dead-time intervals.
module scan_interval_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    // Load wins over decrement; the count parks at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/scan_line_sequencer.sv
// Frame scheduler: fire tx, open listen window, enforce dead time, once per scan line.
// Build option SCAN_CONTINUOUS_EN adds the 'continuous' input for back-to-back frames.
//
// state    | meaning
// IDLE     | waiting for frame_start
// FIRE     | one cycle; tx_start is issued on the following cycle
// WAIT_ACK | waiting up to ACK_TIMEOUT cycles for tx_busy to rise
// WAIT_TX  | waiting for tx_busy to fall
// LISTEN   | receive window, listen_cycles long
// DEAD     | dead time, max(deadtime_cycles,1) long
// DONE     | frame_done cycle
//
// tx_start/listen_window are registered from the state, so they lag it by one cycle.
// Line-to-line tx_start spacing = ack latency + tx busy time + listen + max(dead,1) + 2 cycles
// (with a transmit FSM that raises busy the cycle after tx_start: busy + listen + max(dead,1) + 3).
module scan_line_sequencer
    import scan_seq_pkg::*;
#(
    parameter int LINE_W      = LINE_W_DEF,
    parameter int LISTEN_W    = LISTEN_W_DEF,
    parameter int DEAD_W      = DEAD_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                abort,
    input  logic [LINE_W-1:0]   num_lines,
    input  logic [LISTEN_W-1:0] listen_cycles,
    input  logic [DEAD_W-1:0]   deadtime_cycles,
`ifdef SCAN_CONTINUOUS_EN
    input  logic                continuous,
`endif
    input  logic                tx_busy,
    output logic                tx_start,
    output logic                listen_window,
    output logic [LINE_W-1:0]   line_index,
    output logic                frame_busy,
    output logic                frame_done,
    output logic                tx_timeout
);

    localparam int CNT_W = max3(LISTEN_W, DEAD_W, $clog2(ACK_TIMEOUT + 1));

    scan_state_e         state_q, state_d;
    logic [LINE_W-1:0]   lines_q, lines_d;
    logic [LISTEN_W-1:0] listen_len_q, listen_len_d;
    logic [DEAD_W-1:0]   dead_len_q, dead_len_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                timeout_q, timeout_d;
    logic                done_q, done_d;
    logic                tx_start_q, listen_win_q;

    logic                cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]    cnt_val, listen_ld, dead_ld;

    assign listen_ld = CNT_W'(listen_len_q - 1'b1);
    assign dead_ld   = (dead_len_q == '0) ? '0 : CNT_W'(dead_len_q - 1'b1);

    scan_interval_counter #(.W(CNT_W)) u_interval (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        lines_d      = lines_q;
        listen_len_d = listen_len_q;
        dead_len_d   = dead_len_q;
        line_d       = line_q;
        timeout_d    = timeout_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        timeout_d = 1'b0;
                        if (num_lines == '0) begin
                            done_d = 1'b1;
                        end else begin
                            lines_d      = num_lines;
                            listen_len_d = listen_cycles;
                            dead_len_d   = deadtime_cycles;
                            line_d       = '0;
                            state_d      = FIRE;
                        end
                    end
                end
                FIRE: begin
                    state_d  = WAIT_ACK;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(ACK_TIMEOUT - 1);
                end
                WAIT_ACK: begin
                    cnt_dec = 1'b1;
                    if (tx_busy) begin
                        state_d = WAIT_TX;
                    end else if (cnt_zero) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                WAIT_TX: begin
                    if (!tx_busy) begin
                        cnt_load = 1'b1;
                        if (listen_len_q != '0) begin
                            state_d = LISTEN;
                            cnt_val = listen_ld;
                        end else begin
                            state_d = DEAD;
                            cnt_val = dead_ld;
                        end
                    end
                end
                LISTEN: begin
                    cnt_dec = 1'b1;
                    if (cnt_zero) begin
                        state_d  = DEAD;
                        cnt_load = 1'b1;
                        cnt_val  = dead_ld;
                    end
                end
                DEAD: begin
                    cnt_dec = 1'b1;
                    if (cnt_zero) begin
                        if (line_q == lines_q - 1'b1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            line_d  = line_q + 1'b1;
                            state_d = FIRE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
`ifdef SCAN_CONTINUOUS_EN
                    // A zero line count on reload cannot be scheduled, so fall back to IDLE.
                    if (continuous && (num_lines != '0)) begin
                        lines_d      = num_lines;
                        listen_len_d = listen_cycles;
                        dead_len_d   = deadtime_cycles;
                        line_d       = '0;
                        state_d      = FIRE;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lines_q      <= '0;
            listen_len_q <= '0;
            dead_len_q   <= '0;
            line_q       <= '0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            tx_start_q   <= 1'b0;
            listen_win_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lines_q      <= lines_d;
            listen_len_q <= listen_len_d;
            dead_len_q   <= dead_len_d;
            line_q       <= line_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            tx_start_q   <= (state_q == FIRE) && !abort;
            listen_win_q <= (state_q == LISTEN) && !abort;
        end
    end

    assign tx_start      = tx_start_q;
    assign listen_window = listen_win_q;
    assign line_index    = line_q;
    assign frame_busy    = (state_q != IDLE);
    assign frame_done    = done_q;
    assign tx_timeout    = timeout_q;

endmodule

// File: tb/tb_scan_line_sequencer.sv
// Bench for scan_line_sequencer: randomized frames against a timing model of the line schedule.
module tb_scan_line_sequencer;

    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_lines = '0;
    logic [15:0] listen_cycles = '0;
    logic [11:0] deadtime_cycles = '0;
    logic        tx_busy;
    logic        tx_start, listen_window, frame_busy, frame_done, tx_timeout;
    logic [7:0]  line_index;
`ifdef SCAN_CONTINUOUS_EN
    logic        continuous = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scan_line_sequencer #(
        .LINE_W(8), .LISTEN_W(16), .DEAD_W(12), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .abort           (abort),
        .num_lines       (num_lines),
        .listen_cycles   (listen_cycles),
        .deadtime_cycles (deadtime_cycles),
`ifdef SCAN_CONTINUOUS_EN
        .continuous      (continuous),
`endif
        .tx_busy         (tx_busy),
        .tx_start        (tx_start),
        .listen_window   (listen_window),
        .line_index      (line_index),
        .frame_busy      (frame_busy),
        .frame_done      (frame_done),
        .tx_timeout      (tx_timeout)
    );

    // Transmit FSM stand-in: busy for busy_len cycles starting the cycle after tx_start.
    int busy_left = 0;
    int busy_len = 4;
    bit tx_resp = 1'b1;
    always @(posedge clk) begin
        if (busy_left > 0) busy_left <= busy_left - 1;
        if (tx_start && tx_resp) busy_left <= busy_len;
    end
    assign tx_busy = (busy_left > 0);

    // Event recorder, one sample per cycle away from the active edge.
    int cyc = 0;
    int tx_cyc[$];
    int done_cyc[$];
    int fs_cyc[$];
    int to_cyc[$];
    int lw_len[$];
    int lw_line[$];
    int busy_cnt = 0;
    int idle_cnt = 0;
    bit prev_lw = 1'b0;
    bit prev_to = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (tx_start) tx_cyc.push_back(cyc);
        if (frame_done) done_cyc.push_back(cyc);
        if (frame_start) fs_cyc.push_back(cyc);
        if (tx_timeout && !prev_to) to_cyc.push_back(cyc);
        if (frame_busy) busy_cnt++; else idle_cnt++;
        if (listen_window) begin
            if (!prev_lw) begin
                lw_len.push_back(1);
                lw_line.push_back(int'(line_index));
            end else begin
                lw_len[lw_len.size()-1] = lw_len[lw_len.size()-1] + 1;
            end
        end
        prev_lw = listen_window;
        prev_to = tx_timeout;
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int n, input int l, input int d);
        num_lines       = 8'(n);
        listen_cycles   = 16'(l);
        deadtime_cycles = 12'(d);
        frame_start     = 1'b1;
        @(posedge clk); #1;
        frame_start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!frame_busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        @(negedge clk);
        n_cmp++;
        if ({tx_start, listen_window, frame_busy, frame_done, tx_timeout, line_index} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b, required all 0",
                     {tx_start, listen_window, frame_busy, frame_done, tx_timeout, line_index});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);
    endtask

    // Model: first tx_start 2 cycles after frame_start is sampled; lines spaced busy+listen+max(dead,1)+3;
    // frame_done busy+listen+max(dead,1)+2 after the last tx_start.
    task automatic test_frames();
        int n, l, d, b, dm, sp, fs, tb0, db0, lb0, fb0;
        bit ok;
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin
                n = 3; l = 10; d = 4; b = 20;
            end else begin
                n = $urandom_range(5, 1);
                l = $urandom_range(12, 0);
                d = $urandom_range(6, 0);
                b = $urandom_range(8, 1);
            end
            dm = (d == 0) ? 1 : d;
            sp = b + l + dm + 3;
            busy_len = b;
            tx_resp = 1'b1;
            tb0 = tx_cyc.size(); db0 = done_cyc.size(); lb0 = lw_len.size(); fb0 = fs_cyc.size();
            drive_frame(n, l, d);
            wait_idle(3000, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL frame%0d_idle: frame_busy still 1 after 3000 cycles, required 0", it);
            end
            fs = fs_cyc[fb0];
            n_cmp++;
            if (tx_cyc.size() - tb0 != n) begin
                n_bad++;
                $display("FAIL frame%0d_tx_count: got %0d, required %0d", it, tx_cyc.size() - tb0, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    n_cmp++;
                    if (tx_cyc[tb0+i] != fs + 2 + i * sp) begin
                        n_bad++;
                        $display("FAIL frame%0d_tx%0d_time: got cycle %0d, required %0d",
                                 it, i, tx_cyc[tb0+i], fs + 2 + i * sp);
                    end
                end
            end
            n_cmp++;
            if (lw_len.size() - lb0 != ((l > 0) ? n : 0)) begin
                n_bad++;
                $display("FAIL frame%0d_listen_count: got %0d, required %0d",
                         it, lw_len.size() - lb0, (l > 0) ? n : 0);
            end else begin
                for (int i = 0; i < lw_len.size() - lb0; i++) begin
                    n_cmp++;
                    if (lw_len[lb0+i] != l || lw_line[lb0+i] != i) begin
                        n_bad++;
                        $display("FAIL frame%0d_listen%0d: got len %0d line %0d, required len %0d line %0d",
                                 it, i, lw_len[lb0+i], lw_line[lb0+i], l, i);
                    end
                end
            end
            n_cmp++;
            if (done_cyc.size() - db0 != 1) begin
                n_bad++;
                $display("FAIL frame%0d_done_count: got %0d, required 1", it, done_cyc.size() - db0);
            end else begin
                n_cmp++;
                if (done_cyc[db0] != fs + 2 + (n - 1) * sp + b + l + dm + 2) begin
                    n_bad++;
                    $display("FAIL frame%0d_done_time: got cycle %0d, required %0d",
                             it, done_cyc[db0], fs + 2 + (n - 1) * sp + b + l + dm + 2);
                end
            end
            n_cmp++;
            if (int'(line_index) != n - 1) begin
                n_bad++;
                $display("FAIL frame%0d_line_hold: got %0d, required %0d", it, line_index, n - 1);
            end
            tick(3);
        end
    endtask

    task automatic test_zero_lines();
        int tb0, db0, fb0, bc0;
        tb0 = tx_cyc.size(); db0 = done_cyc.size(); fb0 = fs_cyc.size(); bc0 = busy_cnt;
        drive_frame(0, 5, 2);
        tick(6);
        n_cmp++;
        if (done_cyc.size() - db0 != 1 || tx_cyc.size() - tb0 != 0 || busy_cnt - bc0 != 0) begin
            n_bad++;
            $display("FAIL zero_lines_counts: got done %0d tx %0d busy %0d, required 1 0 0",
                     done_cyc.size() - db0, tx_cyc.size() - tb0, busy_cnt - bc0);
        end else begin
            n_cmp++;
            if (done_cyc[db0] != fs_cyc[fb0] + 1) begin
                n_bad++;
                $display("FAIL zero_lines_done_time: got cycle %0d, required %0d",
                         done_cyc[db0], fs_cyc[fb0] + 1);
            end
        end
    endtask

    task automatic test_timeout();
        int tb0, db0, tob0;
        bit ok;
        tb0 = tx_cyc.size(); db0 = done_cyc.size(); tob0 = to_cyc.size();
        tx_resp = 1'b0;
        drive_frame(2, 5, 1);
        wait_idle(200, ok);
        n_cmp++;
        if (!ok || tx_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_flag: got idle %0d tx_timeout %b, required 1 1", ok, tx_timeout);
        end
        n_cmp++;
        if (tx_cyc.size() - tb0 != 1 || to_cyc.size() - tob0 != 1 || done_cyc.size() - db0 != 0) begin
            n_bad++;
            $display("FAIL timeout_counts: got tx %0d timeout %0d done %0d, required 1 1 0",
                     tx_cyc.size() - tb0, to_cyc.size() - tob0, done_cyc.size() - db0);
        end else begin
            n_cmp++;
            if (to_cyc[tob0] - tx_cyc[tb0] != ACK_TIMEOUT) begin
                n_bad++;
                $display("FAIL timeout_delay: got %0d cycles after tx_start, required %0d",
                         to_cyc[tob0] - tx_cyc[tb0], ACK_TIMEOUT);
            end
        end
        tick(5);
        n_cmp++;
        if (tx_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: got %b, required 1", tx_timeout);
        end
        tx_resp = 1'b1;
        busy_len = 2;
        drive_frame(1, 2, 1);
        @(negedge clk);
        n_cmp++;
        if (tx_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: got %b, required 0", tx_timeout);
        end
        wait_idle(200, ok);
    endtask

    task automatic test_abort();
        int tb0, db0, bc0;
        bit found;
        busy_len = 3;
        tx_resp = 1'b1;
        tb0 = tx_cyc.size(); db0 = done_cyc.size();
        drive_frame(4, 10, 2);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (listen_window && line_index == 8'd1) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL abort_reach_listen1: line 1 listen window not seen in 500 cycles, required seen");
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (listen_window !== 1'b0 || frame_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_drop: got listen %b busy %b, required 0 0", listen_window, frame_busy);
        end
        @(posedge clk); #1;
        tick(80);
        n_cmp++;
        if (tx_cyc.size() - tb0 != 2 || done_cyc.size() - db0 != 0) begin
            n_bad++;
            $display("FAIL abort_after: got tx %0d done %0d, required 2 0",
                     tx_cyc.size() - tb0, done_cyc.size() - db0);
        end
        tb0 = tx_cyc.size(); db0 = done_cyc.size(); bc0 = busy_cnt;
        num_lines = 8'd3;
        frame_start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        abort = 1'b0;
        tick(10);
        n_cmp++;
        if (busy_cnt - bc0 != 0 || tx_cyc.size() - tb0 != 0 || done_cyc.size() - db0 != 0) begin
            n_bad++;
            $display("FAIL abort_with_start: got busy %0d tx %0d done %0d, required 0 0 0",
                     busy_cnt - bc0, tx_cyc.size() - tb0, done_cyc.size() - db0);
        end
    endtask

    task automatic test_busy_ignore();
        int tb0, db0;
        bit ok;
        busy_len = 2;
        tb0 = tx_cyc.size(); db0 = done_cyc.size();
        drive_frame(2, 4, 1);
        tick(5);
        drive_frame(7, 4, 1);
        wait_idle(500, ok);
        n_cmp++;
        if (!ok || tx_cyc.size() - tb0 != 2 || done_cyc.size() - db0 != 1 || line_index !== 8'd1) begin
            n_bad++;
            $display("FAIL busy_ignore: got idle %0d tx %0d done %0d line %0d, required 1 2 1 1",
                     ok, tx_cyc.size() - tb0, done_cyc.size() - db0, line_index);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        busy_len = 10;
        drive_frame(3, 4, 2);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_busy && frame_busy && !tx_start) begin
                found = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (!found || {tx_start, listen_window, frame_busy, frame_done, tx_timeout, line_index} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got found %0d outputs %b, required 1 and all 0", found,
                     {tx_start, listen_window, frame_busy, frame_done, tx_timeout, line_index});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(15);
    endtask

`ifdef SCAN_CONTINUOUS_EN
    task automatic test_continuous();
        int tb0, db0, ic0;
        bit ok;
        busy_len = 2;
        continuous = 1'b1;
        tb0 = tx_cyc.size(); db0 = done_cyc.size();
        drive_frame(2, 3, 1);
        ic0 = idle_cnt;
        tick(60);
        n_cmp++;
        if (idle_cnt - ic0 != 0 || done_cyc.size() - db0 != 3) begin
            n_bad++;
            $display("FAIL continuous_run: got idle %0d done %0d, required 0 3",
                     idle_cnt - ic0, done_cyc.size() - db0);
        end
        n_cmp++;
        if (tx_cyc.size() - tb0 < 3 || tx_cyc[tb0+2] - tx_cyc[tb0+1] != 10) begin
            n_bad++;
            $display("FAIL continuous_gap: got tx count %0d, required >=3 with boundary gap 10",
                     tx_cyc.size() - tb0);
        end
        continuous = 1'b0;
        wait_idle(200, ok);
        n_cmp++;
        if (!ok || (done_cyc.size() - db0) * 2 != tx_cyc.size() - tb0) begin
            n_bad++;
            $display("FAIL continuous_stop: got idle %0d done %0d tx %0d, required idle with tx=2*done",
                     ok, done_cyc.size() - db0, tx_cyc.size() - tb0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_zero_lines();
        test_timeout();
        test_abort();
        test_busy_ignore();
        test_reset_mid();
`ifdef SCAN_CONTINUOUS_EN
        test_continuous();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
